mfe_led7seg_74hc595_shifter: RTL and testbench
==============================================

// Module: mfe_led7seg_74hc595_shifter
// PURPOSE
//  Serialises one DATA_W-bit frame per vld/rdy handshake onto the 3-wire 74HC595 interface (sclk/rclk/dio).
//  Sits directly downstream of the digit-scan/demo logic, which presents {segment_byte, digit_onehot} frames.
//  Shifts MSB first, then pulses rclk to latch the frame onto the 8-digit 7-seg module.
//  Paces all output timing with an internal clock divider, so sclk stays within 74HC595 limits.
// PARAMETERS
//  CLK_DIV  4   clk cycles per sclk half-period; legal values >=1
//  DATA_W   16  frame width in bits; legal values >=2
// PORTS
//  clk   in   1       system clock; all logic on posedge
//  rst   in   1       synchronous reset, active-high
//  dat   in   DATA_W  frame to shift; sampled only on accept
//  vld   in   1       upstream frame valid
//  rdy   out  1       shifter idle, can accept a frame
//  sclk  out  1       74HC595 shift clock (SH_CP)
//  rclk  out  1       74HC595 storage/latch clock (ST_CP)
//  dio   out  1       74HC595 serial data (DS)
// BEHAVIOUR
//  - One clock domain. Reset is synchronous and active-high. All outputs are registered.
//  - Reset values: rdy=0, sclk=0, rclk=0, dio=0, state=IDLE, div/bit counters=0.
//  - rdy rises 1 cycle after rst deasserts.
//  - Accept: the posedge where vld&rdy=1 (edge T). At T, dat is latched into the shift register.
//    At T+1, rdy=0.
//  - vld while rdy=0 is ignored. There is no queue. Changes to dat while busy have no effect.
//  - States: IDLE -> SHIFT -> LATCH -> GAP -> IDLE.
//  - IDLE: rdy=1, sclk=0, rclk=0, dio holds its last value.
//    On accept, go to SHIFT with dio=dat[DATA_W-1] and sclk=0.
//  - SHIFT: each bit lasts 2*CLK_DIV cycles.
//    - Low half: CLK_DIV cycles, sclk=0, dio stable.
//    - High half: CLK_DIV cycles, sclk=1.
//    - On the falling edge of sclk, dio advances to the next lower bit in the same cycle.
//    - dio changes only while sclk=0, so there is >=CLK_DIV cycles of setup and hold around each sclk rise.
//    - After the high half of bit 0, go to LATCH with sclk=0.
//  - LATCH: rclk=1 for CLK_DIV cycles, then go to GAP.
//  - GAP: rclk=0 for CLK_DIV cycles, then go to IDLE with rdy=1.
//  - Latency: with accept at edge T, the first sclk rise is at T+1+CLK_DIV.
//    - rclk is high from T+1+2*CLK_DIV*DATA_W.
//    - rdy=1 again at T+1+2*CLK_DIV*(DATA_W+1). Defaults give T+137.
//  - Exactly DATA_W sclk rising edges and exactly 1 rclk pulse per accepted frame.
//  - Back-to-back: if vld is held at 1 (or tied to rdy), the next accept happens on the first cycle rdy=1.
//    No extra idle cycle is inserted.
//  - Counters: div_cnt counts 0..CLK_DIV-1 and wraps. bit_cnt counts DATA_W-1 down to 0; no wrap beyond 0.
//  - Reset mid-frame: outputs return to reset values at the next edge. No rclk pulse is issued.
//    The partial frame is discarded, and rdy rises 1 cycle after rst deasserts.
//  - vld=1 during rst is ignored.
// TESTING
//  1. Reset with rst=1 for 3 cycles, then release.
//     -> During rst: sclk=rclk=dio=rdy=0. rdy=1 exactly 1 cycle after release.
//  2. Defaults; single frame dat=16'hC001, vld pulsed at accept edge T.
//     -> 16 sclk rises, first at T+5, spaced 8 cycles apart.
//     -> dio sampled at the rises reads 1100_0000_0000_0001.
//     -> rclk=1 during T+129..T+132. rdy=1 at T+137.
//  3. vld tied to rdy; dat cycles 16'hC001,16'hF902,16'hA404.
//     -> Three frames with no gap beyond the GAP state; accepts at T, T+137, T+274.
//     -> Each frame is shifted intact.
//  4. vld=1 with dat=16'hFFFF while busy mid-frame.
//     -> Ignored: the current frame is unchanged and no additional accept occurs until rdy=1.
//  5. rst asserted after the 7th sclk rise.
//     -> No rclk pulse. All outputs are 0 the next cycle.
//     -> After release, frame 16'h8080 shifts correctly.
//  6. CLK_DIV=1, DATA_W=16, frame 16'hAAAA.
//     -> sclk toggles every cycle and dio alternates 1/0 at the rises.
//     -> rclk is high for 1 cycle. rdy returns at T+35.

Source files
------------

// File: rtl/mfe_led7seg_74hc595_shifter.sv
// Serialises one {segment, digit} frame per vld/rdy handshake onto a 74HC595 chain
// (sclk/rclk/dio), MSB first, then pulses rclk to latch it.
module mfe_led7seg_74hc595_shifter #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] dat,
  input  logic              vld,
  output logic              rdy,
  output logic              sclk,
  output logic              rclk,
  output logic              dio
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH,
    S_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic               sclk_q, sclk_d;
  logic               rclk_q, rclk_d;
  logic               rdy_q, rdy_d;
  logic               div_wrap;

  assign div_wrap = (div_q == DIV_LAST);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d = state_q;
    div_d   = div_wrap ? '0 : div_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    rclk_d  = rclk_q;
    rdy_d   = rdy_q;

    unique case (state_q)
      S_IDLE: begin
        div_d  = '0;
        sclk_d = 1'b0;
        rclk_d = 1'b0;
        rdy_d  = 1'b1;
        if (vld && rdy_q) begin
          state_d = S_SHIFT;
          shreg_d = dat;
          bit_d   = BIT_TOP;
          rdy_d   = 1'b0;
        end
      end
      S_SHIFT: begin
        if (div_wrap) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            // Data advances on the falling edge so it is stable across the next rise.
            if (bit_q == '0) begin
              state_d = S_LATCH;
              rclk_d  = 1'b1;
            end else begin
              bit_d   = bit_q - 1'b1;
              shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            end
          end
        end
      end
      S_LATCH: begin
        if (div_wrap) begin
          rclk_d  = 1'b0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (div_wrap) begin
          state_d = S_IDLE;
          rdy_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      // NOTE: the shift register is reset too because its MSB drives dio directly.
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      rclk_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      rclk_q  <= rclk_d;
      rdy_q   <= rdy_d;
    end
  end

  assign rdy  = rdy_q;
  assign sclk = sclk_q;
  assign rclk = rclk_q;
  assign dio  = shreg_q[DATA_W-1];

endmodule

// File: tb/tb_mfe_led7seg_74hc595_shifter.sv
// Self-checking bench: table of frames plus directed abort and CLK_DIV=1 sequences,
// with a queue scoreboard compared at each rclk pulse.
module tb_mfe_led7seg_74hc595_shifter;

  typedef struct {
    logic [15:0] dat;
    logic [15:0] exp_bits;
    bit          hold;
    bit          poke;
    int          abort_rises;
    bit          sel;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst0, rst1, vld0, vld1;
  logic [15:0] dat0, dat1;
  logic        rdy0, sclk0, rclk0, dio0;
  logic        rdy1, sclk1, rclk1, dio1;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          last_t = 0;
  bit          prev_hold = 1'b0;
  logic [15:0] exp_q[$];
  vec_t        vecs[4];

  mfe_led7seg_74hc595_shifter #(.CLK_DIV(4), .DATA_W(16)) dut (
    .clk(clk), .rst(rst0), .dat(dat0), .vld(vld0),
    .rdy(rdy0), .sclk(sclk0), .rclk(rclk0), .dio(dio0)
  );

  mfe_led7seg_74hc595_shifter #(.CLK_DIV(1), .DATA_W(16)) dut1 (
    .clk(clk), .rst(rst1), .dat(dat1), .vld(vld1),
    .rdy(rdy1), .sclk(sclk1), .rclk(rclk1), .dio(dio1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [15:0] d);
    if (sel) begin vld1 = v; dat1 = d; end
    else     begin vld0 = v; dat0 = d; end
  endtask

  task automatic set_rst(input bit sel, input logic r);
    if (sel) rst1 = r; else rst0 = r;
  endtask

  function automatic logic [3:0] outs_of(input bit sel);  // {rdy, sclk, rclk, dio}
    return sel ? {rdy1, sclk1, rclk1, dio1} : {rdy0, sclk0, rclk0, dio0};
  endfunction

  // k counts edges after the accept edge T; values are observed #1 after edge T+k,
  // i.e. the edge that updates a register, one edge before it is next sampled.
  task automatic run_frame(input vec_t v);
    int          c, k, kmax, rises, rclk_hi, viol, wait_n, t_acc;
    logic [15:0] cap, exp;
    logic [3:0]  o, p;
    bit          done;
    c       = v.sel ? 1 : 4;
    kmax    = 2 * c * 17 + 8;
    rises   = 0;
    rclk_hi = 0;
    viol    = 0;
    cap     = '0;
    done    = 1'b0;
    drive(v.sel, 1'b1, v.dat);
    exp_q.push_back(v.exp_bits);
    wait_n = 0;
    while (!outs_of(v.sel)[3] && wait_n < 400) begin
      @(posedge clk); #1;
      wait_n++;
    end
    if (!outs_of(v.sel)[3]) begin
      check("accept_timeout", 0, 1);
      return;
    end
    @(posedge clk); #1;
    t_acc = cyc;
    if (prev_hold) check("b2b_spacing", t_acc - last_t, 2 * c * 17 + 1);
    last_t    = t_acc;
    prev_hold = v.hold;
    drive(v.sel, v.hold, 16'($urandom));
    p = outs_of(v.sel);
    check("rdy_drop", p[3], 1'b0);
    check("first_dio", p[0], v.exp_bits[15]);
    k = 0;
    while (!done && k < kmax) begin
      @(posedge clk); #1;
      k++;
      if (v.poke && k == 60) drive(v.sel, 1'b1, 16'hFFFF);
      if (v.poke && k == 70) drive(v.sel, 1'b0, 16'hFFFF);
      o = outs_of(v.sel);
      if (o[2] && o[0] != p[0]) viol++;
      if (o[2] && !p[2]) begin
        rises++;
        check("sclk_rise_k", k, c + 2 * c * (rises - 1));
        cap = {cap[14:0], o[0]};
        if (rises == v.abort_rises) begin
          set_rst(v.sel, 1'b1);
          @(posedge clk); #1;
          check("abort_outs_zero", outs_of(v.sel), 4'b0000);
          repeat (2) begin
            @(posedge clk); #1;
            check("abort_hold_zero", outs_of(v.sel), 4'b0000);
          end
          set_rst(v.sel, 1'b0);
          @(posedge clk); #1;
          check("abort_rdy", outs_of(v.sel), 4'b1000);
          check("abort_no_rclk", rclk_hi, 0);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          prev_hold = 1'b0;
          return;
        end
      end
      if (o[1]) begin
        rclk_hi++;
        if (!p[1]) begin
          check("rclk_rise_k", k, 2 * c * 16);
          check("sclk_rise_count", rises, 16);
          if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
          end else begin
            exp = exp_q.pop_front();
            check("frame_bits", cap, exp);
          end
        end
      end
      if (o[3]) done = 1'b1;
      p = o;
    end
    check("rdy_return_k", k, 2 * c * 17);
    check("rclk_width", rclk_hi, c);
    check("dio_stable_sclk_hi", viol, 0);
  endtask

  initial begin
    vecs[0] = '{dat: 16'hC001, exp_bits: 16'b1100_0000_0000_0001, hold: 1'b0, poke: 1'b0, abort_rises: 0, sel: 1'b0};
    vecs[1] = '{dat: 16'hC001, exp_bits: 16'b1100_0000_0000_0001, hold: 1'b1, poke: 1'b0, abort_rises: 0, sel: 1'b0};
    vecs[2] = '{dat: 16'hF902, exp_bits: 16'b1111_1001_0000_0010, hold: 1'b1, poke: 1'b0, abort_rises: 0, sel: 1'b0};
    vecs[3] = '{dat: 16'hA404, exp_bits: 16'b1010_0100_0000_0100, hold: 1'b0, poke: 1'b1, abort_rises: 0, sel: 1'b0};

    rst0 = 1'b1;
    rst1 = 1'b1;
    vld0 = 1'b1;
    vld1 = 1'b1;
    dat0 = 16'hFFFF;
    dat1 = 16'hFFFF;
    repeat (3) begin
      @(posedge clk); #1;
      check("reset_outs", outs_of(1'b0), 4'b0000);
      check("reset_outs_div1", outs_of(1'b1), 4'b0000);
    end
    vld0 = 1'b0;
    vld1 = 1'b0;
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(posedge clk); #1;
    check("rdy_after_release", outs_of(1'b0), 4'b1000);
    check("rdy_after_release_div1", outs_of(1'b1), 4'b1000);

    for (int i = 0; i < 4; i++) run_frame(vecs[i]);

    // Reset after the 7th sclk rise, then a clean frame.
    run_frame('{dat: 16'h1234, exp_bits: 16'b0001_0010_0011_0100, hold: 1'b0, poke: 1'b0, abort_rises: 7, sel: 1'b0});
    run_frame('{dat: 16'h8080, exp_bits: 16'b1000_0000_1000_0000, hold: 1'b0, poke: 1'b0, abort_rises: 0, sel: 1'b0});

    // Fastest divider: sclk toggles every cycle.
    run_frame('{dat: 16'hAAAA, exp_bits: 16'b1010_1010_1010_1010, hold: 1'b0, poke: 1'b0, abort_rises: 0, sel: 1'b1});

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
